risc16_mc_ctrl: RTL and testbench
=================================

# risc16_mc_ctrl

Multicycle control sequencer for the RiSC-16 datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states over a single shared instruction/data memory port that accepts variable wait states. It drives every datapath enable and mux select: PC, IR, register-file write, ALU, and memory. It also detects HALT, retires instructions into a counter, and traps to a FAULT state on memory timeout.

## Interface
- TIMEOUT, 255: maximum consecutive wait cycles (mem_req high, mem_ready low) tolerated before FAULT.
- CNT_W, 16: width of the retired-instruction counter.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  16  memory read data; the controller samples bits [15:13] and [6:0] on fetch completion.
- mem_ready  in  1  memory handshake; the access completes in any cycle where mem_req and mem_ready are both high.
- alu_eq  in  1  datapath equality flag (reg_out1 == reg_out2), valid in EXEC.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; qualifies mem_req.
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction-register load.
- pc_we  out  1  PC load.
- pc_sel  out  2  next-PC source: 00 = PC+1, 01 = PC+1+simm7, 10 = reg_out1.
- WE_rf  out  1  register-file write enable.
- rf_wsel  out  2  write-back source: 00 = ALU, 01 = mem_rdata, 10 = PC+1.
- alu_op  out  2  ALU function: 00 = add, 01 = nand, 10 = pass-B (LUI), 11 = compare.
- alu_src_imm  out  1  ALU B operand: 1 = immediate, 0 = register.
- src2_sel  out  1  second read port: 0 = rC, 1 = rA (SW, BEQ).
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- retired  out  CNT_W  retired-instruction count.

## Operation
- Latched fields: on fetch completion the controller latches op = mem_rdata[15:13] and imm_nz = |mem_rdata[6:0]. op and imm_nz hold their values until the next fetch completes.
- Outputs are combinational from state, op, imm_nz, and, where stated below, mem_ready or alu_eq. Every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0, ir_we=mem_ready.
  - Transition on mem_ready to DECODE.
- DECODE:
  - Outputs: src2_sel=1 for op SW or BEQ.
  - Transition: always to EXEC.
- EXEC:
  - ALU settings by op:
    - ADD (000): alu_op=00.
    - ADDI (001): alu_op=00, alu_src_imm=1.
    - NAND (010): alu_op=01.
    - LUI (011): alu_op=10, alu_src_imm=1.
    - LW/SW (101/100): alu_op=00, alu_src_imm=1.
    - BEQ (110): alu_op=11.
  - BEQ completes here: pc_we=1, pc_sel = alu_eq ? 01 : 00, retire, go to FETCH.
  - JALR (111) with imm_nz=1 goes to HALT: no PC write, no retire.
  - JALR with imm_nz=0 goes to WB.
  - LW and SW go to MEM.
  - All other ops go to WB.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=(op==SW), ALU settings as in EXEC.
  - On mem_ready:
    - SW: pc_we=1, pc_sel=00, retire, go to FETCH.
    - LW: go to WB.
- WB:
  - Outputs: WE_rf=1, pc_we=1.
  - rf_wsel: 01 for LW, 10 for JALR, 00 otherwise.
  - pc_sel: 10 for JALR, 00 otherwise.
  - ALU settings as in EXEC.
  - Retire, go to FETCH.
- HALT: all outputs 0 except halted=1. Exits only on rst.
- FAULT: all outputs 0 except fault=1. Exits only on rst.
- Retire: retired increments by 1 in exactly the cycle an instruction's PC write occurs. It wraps from 2^CNT_W-1 to 0.
- Timeout:
  - wait_cnt increments each cycle in FETCH or MEM with mem_ready=0, and clears on completion or state exit.
  - When wait_cnt==TIMEOUT and mem_ready is still 0, the next state is FAULT.
  - A mem_ready arriving in that same cycle wins: the access completes and no fault occurs.
- Register-file writes with rA=0 are still asserted; the register file discards them.

## Timing
- rst high at a clock edge leads to FETCH, wait_cnt=0, retired=0, op=000, imm_nz=0.
- While rst is high, every output is forced to 0, including mem_req.
- The first mem_req appears in the cycle after rst deasserts.
- rst overrides every state, including mid-MEM; an in-flight write is simply dropped.
- Cycles per instruction with zero wait states:
  - BEQ: 3.
  - ADD, ADDI, NAND, LUI, SW, JALR: 4.
  - LW: 5.
- Each wait cycle adds 1 cycle to FETCH or MEM.
- PC, IR and register-file writes take effect at the clock edge that ends the asserting state.
- mem_ready is ignored outside FETCH and MEM.
- mem_we is never high without mem_req.
- Exactly one pc_we pulse per retired instruction.

## Test plan
- Reset: hold rst for 3 cycles, then release. Required: all outputs 0 during reset; mem_req=1, mem_addr_sel=0 on the first cycle after; retired=0.
- ADD then ADDI with mem_ready tied high. Required: 4 cycles each; WE_rf and pc_we high only in WB; retired=2 after 8 cycles.
- LW with 3 fetch wait cycles and 2 MEM wait cycles. Required: ir_we only in the cycle mem_ready rises; instruction takes 10 cycles; rf_wsel=01 in WB.
- BEQ with alu_eq=1, then again with alu_eq=0. Required: 3 cycles each; pc_sel=01 then 00; WE_rf stays 0.
- JALR with imm 0 (mem_rdata=16'hE000). Required: WB shows rf_wsel=10, pc_sel=10. Then JALR with mem_rdata=16'hE071. Required: HALT, halted=1, retired unchanged, no further mem_req until rst.
- With TIMEOUT=4, hold mem_ready low in FETCH for 5 cycles. Required: fault=1 on the next cycle. Repeat with mem_ready rising in the 5th cycle. Required: no fault, transition to DECODE.

Source files
------------

// File: rtl/risc16_mc_ctrl.sv
// Multicycle control sequencer for the RiSC-16 datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with wait states.
module risc16_mc_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic             alu_eq,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             WE_rf,
    output logic [1:0]       rf_wsel,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic             src2_sel,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic             imm_nz_q;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       op_alu;
    logic             op_imm;

    // Only the opcode and the JALR immediate matter here; the rest is datapath.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[12:7];

    assign retired = retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 3'b000;
            imm_nz_q  <= 1'b0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_FETCH && mem_ready) begin
                op_q     <= mem_rdata[15:13];
                imm_nz_q <= |mem_rdata[6:0];
            end
            if (pc_we)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        op_alu = 2'b00;
        op_imm = 1'b0;
        case (op_q)
            OP_ADDI:      op_imm = 1'b1;
            OP_NAND:      op_alu = 2'b01;
            OP_LUI:       begin op_alu = 2'b10; op_imm = 1'b1; end
            OP_SW, OP_LW: op_imm = 1'b1;
            OP_BEQ:       op_alu = 2'b11;
            default:      ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        WE_rf        = 1'b0;
        rf_wsel      = 2'b00;
        alu_op       = 2'b00;
        alu_src_imm  = 1'b0;
        src2_sel     = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready)
                    state_d = S_DECODE;
                else if (wait_q == WW'(TIMEOUT))
                    state_d = S_FAULT;
                else
                    wait_d = wait_q + WW'(1);
            end
            S_DECODE: begin
                src2_sel = (op_q == OP_SW) || (op_q == OP_BEQ);
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                alu_op      = op_alu;
                alu_src_imm = op_imm;
                case (op_q)
                    OP_BEQ: begin
                        pc_we   = 1'b1;
                        pc_sel  = {1'b0, alu_eq};
                        state_d = S_FETCH;
                    end
                    OP_JALR:      state_d = imm_nz_q ? S_HALT : S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_SW);
                alu_op       = op_alu;
                alu_src_imm  = op_imm;
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WW'(TIMEOUT)) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                WE_rf       = 1'b1;
                pc_we       = 1'b1;
                alu_op      = op_alu;
                alu_src_imm = op_imm;
                if (op_q == OP_LW)
                    rf_wsel = 2'b01;
                else if (op_q == OP_JALR)
                    rf_wsel = 2'b10;
                if (op_q == OP_JALR)
                    pc_sel = 2'b10;
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_FAULT;
        endcase

        // Reset silences the port immediately, even mid-access.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_sel       = 2'b00;
            WE_rf        = 1'b0;
            rf_wsel      = 2'b00;
            alu_op       = 2'b00;
            alu_src_imm  = 1'b0;
            src2_sel     = 1'b0;
            halted       = 1'b0;
            fault        = 1'b0;
        end
    end

endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// Randomized bench for risc16_mc_ctrl: each instruction is expanded into the
// cycle-by-cycle control pattern it should produce, then compared per cycle.
module tb_risc16_mc_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       we_rf;
        logic [1:0] rf_wsel;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       src2_sel;
        logic       halted;
        logic       fault;
    } ctl_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   mem_rdata = 16'h0;
    logic          mem_ready = 1'b0;
    logic          alu_eq = 1'b0;
    logic          mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]    pc_sel, rf_wsel, alu_op;
    logic          WE_rf, alu_src_imm, src2_sel, halted, fault;
    logic [CW-1:0] retired;
    ctl_t          obs;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    risc16_mc_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_eq(alu_eq), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .WE_rf(WE_rf), .rf_wsel(rf_wsel), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .src2_sel(src2_sel), .halted(halted),
        .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, WE_rf,
                  rf_wsel, alu_op, alu_src_imm, src2_sel, halted, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then compare outputs.
    task automatic step(input logic rs, input logic rdy, input logic [15:0] rd,
                        input logic eq, input ctl_t e, input string tag);
        @(negedge clk);
        rst = rs; mem_ready = rdy; mem_rdata = rd; alu_eq = eq;
        #1;
        check(tag, 32'(obs), 32'(e));
    endtask

    // {alu_op, alu_src_imm} from the opcode table.
    function automatic logic [2:0] alu_of(input logic [2:0] op);
        case (op)
            3'b000:         return 3'b000;
            3'b001:         return 3'b001;
            3'b010:         return 3'b010;
            3'b011:         return 3'b101;
            3'b100, 3'b101: return 3'b001;
            3'b110:         return 3'b110;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] ret_mod(input int n);
        return 32'(n % (1 << CW));
    endfunction

    task automatic do_reset(input int n);
        ctl_t z = '0;
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), z, "reset_outputs");
        exp_ret = 0;
    endtask

    // term: 0 = retired normally, 1 = halted, 2 = timed out.
    task automatic run_instr(input logic [2:0] op, input logic [6:0] imm,
                             input int fw, input int mw, input logic eq, output int term);
        ctl_t e;
        logic [15:0] w = {op, 6'($urandom), imm};
        bit is_mem = (op == 3'b100) || (op == 3'b101);
        term = 0;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_req = 1'b1;
            step(1'b0, 1'b0, 16'($urandom), 1'($urandom), e, "fetch_wait");
            if (i == 0) check("retired", 32'(retired), ret_mod(exp_ret));
        end
        if (fw > TMO) begin
            term = 2;
        end else begin
            e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
            step(1'b0, 1'b1, w, 1'($urandom), e, "fetch_done");
            if (fw == 0) check("retired", 32'(retired), ret_mod(exp_ret));
            e = '0; e.src2_sel = (op == 3'b100) || (op == 3'b110);
            step(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), e, "decode");
            e = '0; {e.alu_op, e.alu_src_imm} = alu_of(op);
            if (op == 3'b110) begin
                e.pc_we = 1'b1; e.pc_sel = eq ? 2'b01 : 2'b00;
            end
            step(1'b0, 1'($urandom), 16'($urandom), eq, e, "exec");
            if (op == 3'b110) begin
                exp_ret++;
            end else if (op == 3'b111 && imm != 7'd0) begin
                term = 1;
            end else begin
                if (is_mem) begin
                    e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
                    e.mem_we = (op == 3'b100);
                    {e.alu_op, e.alu_src_imm} = alu_of(op);
                    for (int i = 0; i < mw; i++)
                        step(1'b0, 1'b0, 16'($urandom), 1'($urandom), e, "mem_wait");
                    if (mw > TMO) begin
                        term = 2;
                    end else begin
                        e.pc_we = (op == 3'b100);
                        step(1'b0, 1'b1, 16'($urandom), 1'($urandom), e, "mem_done");
                        if (op == 3'b100) exp_ret++;
                    end
                end
                if (term == 0 && op != 3'b100) begin
                    e = '0; e.we_rf = 1'b1; e.pc_we = 1'b1;
                    {e.alu_op, e.alu_src_imm} = alu_of(op);
                    e.rf_wsel = (op == 3'b101) ? 2'b01 : (op == 3'b111) ? 2'b10 : 2'b00;
                    e.pc_sel  = (op == 3'b111) ? 2'b10 : 2'b00;
                    step(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), e, "writeback");
                    exp_ret++;
                end
            end
        end
        $display("instr op=%b imm=%h fw=%0d mw=%0d eq=%b term=%0d retired_model=%0d",
                 op, imm, fw, mw, eq, term, exp_ret);
    endtask

    // Terminal states must hold with random inputs until reset.
    task automatic idle_then_reset(input int term);
        ctl_t e = '0;
        e.halted = (term == 1);
        e.fault  = (term == 2);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), e, "terminal_hold");
        check("retired_frozen", 32'(retired), ret_mod(exp_ret));
        do_reset(2);
    endtask

    initial begin
        int t;
        do_reset(3);
        run_instr(3'b000, 7'h12, 0, 0, 1'b0, t);   // ADD
        run_instr(3'b001, 7'h05, 0, 0, 1'b0, t);   // ADDI
        run_instr(3'b101, 7'h01, 3, 2, 1'b0, t);   // LW with waits
        run_instr(3'b110, 7'h03, 0, 0, 1'b1, t);   // BEQ taken
        run_instr(3'b110, 7'h03, 0, 0, 1'b0, t);   // BEQ not taken
        run_instr(3'b100, 7'h02, 4, 4, 1'b0, t);   // SW, ready on last allowed cycle
        run_instr(3'b111, 7'h00, 0, 0, 1'b0, t);   // JALR
        run_instr(3'b111, 7'h71, 0, 0, 1'b0, t);   // JALR -> HALT
        idle_then_reset(t);
        run_instr(3'b000, 7'h00, TMO + 1, 0, 1'b0, t);  // fetch timeout
        idle_then_reset(t);
        run_instr(3'b101, 7'h00, 1, TMO + 1, 1'b0, t);  // MEM timeout
        idle_then_reset(t);
        for (int k = 0; k < 80; k++) begin
            logic [2:0] op  = 3'($urandom);
            logic [6:0] imm = 7'($urandom);
            int fw = ($urandom_range(0, 24) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            int mw = ($urandom_range(0, 24) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            if (op == 3'b111 && $urandom_range(0, 3) != 0) imm = 7'd0;
            run_instr(op, imm, fw, mw, 1'($urandom), t);
            if (t != 0) idle_then_reset(t);
        end
        run_instr(3'b000, 7'h00, 0, 0, 1'b0, t);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
